// File: rtl/shift_seq_if.sv
// Handshake and data bundle between datapath control (master) and the shift sequencer (slave).
interface shift_seq_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) ();

    logic             start;
    logic             dir;
    logic [CNT_W-1:0] amt;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;

    modport master (
        output start,
        output dir,
        output amt,
        output din,
        input  busy,
        input  done,
        input  dout
    );

    modport slave (
        input  start,
        input  dir,
        input  amt,
        input  din,
        output busy,
        output done,
        output dout
    );

endinterface

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: one zero-fill shift per clock for amt cycles, then a done pulse.
module shift_seq_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic      clk,
    input  logic      rst,
    shift_seq_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] w_work_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_dir;
    logic             w_dir_next;
    logic [WIDTH-1:0] w_shifted;

    // Vacated bit is zero-filled; the bit shifted out is dropped.
    always_comb begin
        if (r_dir) begin
            w_shifted = {r_work[WIDTH-2:0], 1'b0};
        end else begin
            w_shifted = {1'b0, r_work[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_work  <= '0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_work  <= w_work_next;
            r_cnt   <= w_cnt_next;
            r_dir   <= w_dir_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_work_next  = r_work;
        w_cnt_next   = r_cnt;
        w_dir_next   = r_dir;

        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_work_next  = bus.din;
                    w_cnt_next   = bus.amt;
                    w_dir_next   = bus.dir;
                    w_state_next = (bus.amt == '0) ? StDone : StShift;
                end
            end
            StShift: begin
                w_work_next = w_shifted;
                w_cnt_next  = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign bus.busy = (r_state == StShift);
    assign bus.done = (r_state == StDone);
    assign bus.dout = r_work;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench: directed cases plus random traffic against a cycle-level behavioural model.
module tb_shift_seq_ctrl;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   done_cnt;

    shift_seq_if #(.WIDTH(4), .CNT_W(3)) bus ();

    shift_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: phase 0 idle, 1 shifting, 2 done; output is the operand shifted by steps taken so far.
    int         m_phase;
    int         m_step;
    int         m_amt;
    logic       m_dir;
    logic [3:0] m_op;
    logic [3:0] m_out;
    bit         m_ok;

    function automatic logic [3:0] shifted(logic [3:0] op, int n, logic d);
        if (n >= 4) return 4'b0000;
        return d ? 4'(op << n) : 4'(op >> n);
    endfunction

    initial begin
        m_ok    = 1'b0;
        m_phase = 0;
        m_step  = 0;
        m_amt   = 0;
        m_dir   = 1'b0;
        m_op    = '0;
        m_out   = '0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_out   = '0;
            m_ok    = 1'b1;
        end else if (m_ok) begin
            case (m_phase)
                0: if (bus.start) begin
                    m_op    = bus.din;
                    m_amt   = int'(bus.amt);
                    m_dir   = bus.dir;
                    m_step  = 0;
                    m_out   = bus.din;
                    m_phase = (bus.amt == 3'd0) ? 2 : 1;
                end
                1: begin
                    m_step  = m_step + 1;
                    m_out   = shifted(m_op, m_step, m_dir);
                    if (m_step == m_amt) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(posedge clk) begin
        if (bus.done === 1'b1) done_cnt = done_cnt + 1;
    end

    always @(negedge clk) begin
        if (m_ok) begin
            vectors = vectors + 1;
            if (bus.busy !== (m_phase == 1) || bus.done !== (m_phase == 2) ||
                bus.dout !== m_out) begin
                miscompares = miscompares + 1;
                $display("FAIL model t=%0t: got busy=%b done=%b dout=%b, expected busy=%b done=%b dout=%b",
                         $time, bus.busy, bus.done, bus.dout, (m_phase == 1), (m_phase == 2), m_out);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    logic [3:0] trace [0:31];

    // Called at a negedge with the DUT idle; returns cycles from accept to done, and the result.
    task automatic run_op(input logic [3:0] d, input logic [2:0] a, input logic dr,
                          output int cyc, output logic [3:0] res);
        bus.din   = d;
        bus.amt   = a;
        bus.dir   = dr;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.din   = 4'($urandom);
        bus.amt   = 3'($urandom);
        bus.dir   = 1'($urandom);
        cyc = 1;
        trace[1] = bus.dout;
        while (bus.done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc = cyc + 1;
            trace[cyc] = bus.dout;
        end
        if (bus.done !== 1'b1) chk("done_timeout", 32'(bus.done), 32'd1);
        res = bus.dout;
        @(negedge clk);
    endtask

    int         cyc;
    int         c0;
    logic [3:0] res;

    initial begin
        vectors     = 0;
        miscompares = 0;
        done_cnt    = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.din     = '0;
        bus.amt     = '0;
        bus.dir     = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_dout", 32'(bus.dout), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(4'b1011, 3'd1, 1'b0, cyc, res);
        chk("r1_latency", 32'(cyc), 32'd2);
        chk("r1_dout", 32'(res), 32'b0101);

        run_op(4'b1011, 3'd2, 1'b1, cyc, res);
        chk("l2_latency", 32'(cyc), 32'd3);
        chk("l2_mid", 32'(trace[2]), 32'b0110);
        chk("l2_dout", 32'(res), 32'b1100);

        run_op(4'b1001, 3'd0, 1'b0, cyc, res);
        chk("z0_latency", 32'(cyc), 32'd1);
        chk("z0_dout", 32'(res), 32'b1001);

        run_op(4'b1111, 3'd7, 1'b0, cyc, res);
        chk("r7_latency", 32'(cyc), 32'd8);
        chk("r7_dout", 32'(res), 32'b0000);
        chk("r7_done_once", 32'(bus.done), 32'd0);

        // Starts while busy and during done must be dropped.
        c0 = done_cnt;
        bus.din = 4'b1000; bus.amt = 3'd3; bus.dir = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.din = 4'b0001; bus.amt = 3'd1; bus.dir = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("ign_done", 32'(bus.done), 32'd1);
        chk("ign_dout", 32'(bus.dout), 32'b0001);
        bus.start = 1'b1; bus.amt = 3'd0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("ign_idle_busy", 32'(bus.busy), 32'd0);
        chk("ign_idle_done", 32'(bus.done), 32'd0);
        chk("ign_idle_dout", 32'(bus.dout), 32'b0001);
        chk("ign_pulses", 32'(done_cnt - c0), 32'd1);

        // Reset mid-operation abandons it without a done pulse.
        bus.din = 4'b1111; bus.amt = 3'd5; bus.dir = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("abort_busy_pre", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_dout", 32'(bus.dout), 32'd0);
        c0 = done_cnt;
        repeat (8) @(negedge clk);
        chk("abort_no_pulse", 32'(done_cnt - c0), 32'd0);
        run_op(4'b0011, 3'd1, 1'b1, cyc, res);
        chk("post_latency", 32'(cyc), 32'd2);
        chk("post_dout", 32'(res), 32'b0110);

        // Random traffic; the model check runs every cycle.
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(63) == 0);
            bus.start = ($urandom_range(2) == 0);
            bus.din   = 4'($urandom);
            bus.amt   = 3'($urandom);
            bus.dir   = 1'($urandom);
            @(negedge clk);
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
